branch_queue: RTL and testbench

BRANCH_QUEUE -- requirements
Module: branch_queue

---
 rtl/branch_queue_pkg.sv | 23 ++
 rtl/branch_queue.sv | 119 +++++++++++
 tb/tb_branch_queue.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_queue_pkg.sv
// Shared processor definitions for the branch queue, the BPB and the dispatch unit.
// Holds the default queue geometry and the layout of one in-flight branch entry.
package branch_queue_pkg;

  localparam int BRQ_DEPTH    = 4;
  localparam int BRQ_BPB_ADDR = 3;
  localparam int BRQ_PC_W     = 32;
  localparam int BRQ_TAG_W    = $clog2(BRQ_DEPTH);

  typedef struct packed {
    logic                    valid;
    logic                    resolved;
    logic [BRQ_BPB_ADDR-1:0] bpb_addr;
    logic                    pred;
    logic                    taken;
    logic [BRQ_PC_W-1:0]     alt_pc;
  } brq_entry_t;

  function automatic logic is_mispredict(input logic pred, input logic taken);
    return pred != taken;
  endfunction

endpackage

// File: rtl/branch_queue.sv
// In-order branch queue: tags dispatched branches, records CDB outcomes and retires
// them in order, training the BPB and raising a registered flush on a misprediction.
module branch_queue
  import branch_queue_pkg::*;
#(
  parameter int DEPTH    = BRQ_DEPTH,
  parameter int BPB_ADDR = BRQ_BPB_ADDR,
  parameter int PC_W     = BRQ_PC_W,
  localparam int TAG_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                du_push,
  input  logic [BPB_ADDR-1:0] du_bpb_addr,
  input  logic                du_prediction,
  input  logic [PC_W-1:0]     du_alt_pc,
  output logic [TAG_W-1:0]    brq_tag_du,
  output logic                brq_full,
  output logic [TAG_W:0]      brq_count,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic                cdb_taken,
  output logic                cdb_branch,
  output logic                cdb_branch_res,
  output logic [BPB_ADDR-1:0] cdb_bpb_addr,
  output logic                flush,
  output logic [PC_W-1:0]     flush_pc
);

  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    resolved_q;
  logic [DEPTH-1:0]    pred_q;
  logic [DEPTH-1:0]    taken_q;
  logic [BPB_ADDR-1:0] bpb_addr_q [DEPTH];
  logic [PC_W-1:0]     alt_pc_q   [DEPTH];
  logic [TAG_W-1:0]    head_q;
  logic [TAG_W-1:0]    tail_q;
  logic [TAG_W:0]      count_q;

  logic push_ok;
  logic resolve_ok;
  logic retire;
  logic mispredict;

  assign brq_full   = (count_q == (TAG_W+1)'(DEPTH));
  assign brq_count  = count_q;
  assign brq_tag_du = tail_q;

  // The registered flush marks the recovery cycle, in which new work is not accepted.
  always_comb begin
    push_ok    = du_push && !brq_full && !flush;
    resolve_ok = cdb_valid && !flush && valid_q[cdb_tag] && !resolved_q[cdb_tag];
    retire     = valid_q[head_q] && resolved_q[head_q];
    mispredict = retire && is_mispredict(pred_q[head_q], taken_q[head_q]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= '0;
      resolved_q     <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      cdb_branch     <= 1'b0;
      cdb_branch_res <= 1'b0;
      cdb_bpb_addr   <= '0;
      flush          <= 1'b0;
      flush_pc       <= '0;
    end else begin
      cdb_branch     <= retire;
      cdb_branch_res <= retire && taken_q[head_q];
      flush          <= mispredict;
      if (retire) begin
        cdb_bpb_addr <= bpb_addr_q[head_q];
      end
      // A mispredicted retire squashes every younger branch, including a same-cycle push.
      if (mispredict) begin
        flush_pc   <= alt_pc_q[head_q];
        valid_q    <= '0;
        resolved_q <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
      end else begin
        if (resolve_ok) begin
          resolved_q[cdb_tag] <= 1'b1;
        end
        if (retire) begin
          valid_q[head_q]    <= 1'b0;
          resolved_q[head_q] <= 1'b0;
          head_q             <= head_q + TAG_W'(1);
        end
        if (push_ok) begin
          valid_q[tail_q]    <= 1'b1;
          resolved_q[tail_q] <= 1'b0;
          tail_q             <= tail_q + TAG_W'(1);
        end
        if (push_ok && !retire) begin
          count_q <= count_q + (TAG_W+1)'(1);
        end else if (retire && !push_ok) begin
          count_q <= count_q - (TAG_W+1)'(1);
        end
      end
    end
  end

  // Payload fields are only read while their entry is valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      bpb_addr_q[tail_q] <= du_bpb_addr;
      pred_q[tail_q]     <= du_prediction;
      alt_pc_q[tail_q]   <= du_alt_pc;
    end
    if (resolve_ok) begin
      taken_q[cdb_tag] <= cdb_taken;
    end
  end

endmodule

// File: tb/tb_branch_queue.sv
// Directed bench for branch_queue: tagging, full handling, in-order retire,
// BPB training pulses, misprediction flush and reset override.
module tb_branch_queue;

  localparam int DEPTH    = 4;
  localparam int BPB_ADDR = 3;
  localparam int PC_W     = 32;
  localparam int TAG_W    = 2;

  logic                clk;
  logic                reset;
  logic                du_push;
  logic [BPB_ADDR-1:0] du_bpb_addr;
  logic                du_prediction;
  logic [PC_W-1:0]     du_alt_pc;
  logic [TAG_W-1:0]    brq_tag_du;
  logic                brq_full;
  logic [TAG_W:0]      brq_count;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic                cdb_taken;
  logic                cdb_branch;
  logic                cdb_branch_res;
  logic [BPB_ADDR-1:0] cdb_bpb_addr;
  logic                flush;
  logic [PC_W-1:0]     flush_pc;

  int checkCount = 0;
  int failCount  = 0;

  branch_queue #(.DEPTH(DEPTH), .BPB_ADDR(BPB_ADDR), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset),
    .du_push(du_push), .du_bpb_addr(du_bpb_addr), .du_prediction(du_prediction),
    .du_alt_pc(du_alt_pc), .brq_tag_du(brq_tag_du), .brq_full(brq_full),
    .brq_count(brq_count), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_taken(cdb_taken), .cdb_branch(cdb_branch), .cdb_branch_res(cdb_branch_res),
    .cdb_bpb_addr(cdb_bpb_addr), .flush(flush), .flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic push, input logic [BPB_ADDR-1:0] addr,
                               input logic pred, input logic [PC_W-1:0] alt,
                               input logic cv, input logic [TAG_W-1:0] ctag,
                               input logic ctaken);
    du_push       = push;
    du_bpb_addr   = addr;
    du_prediction = pred;
    du_alt_pc     = alt;
    cdb_valid     = cv;
    cdb_tag       = ctag;
    cdb_taken     = ctaken;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic doReset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    doReset();

    checkOutput("rst_count", brq_count, 0);
    checkOutput("rst_full", brq_full, 0);
    checkOutput("rst_tag", brq_tag_du, 0);
    checkOutput("rst_cdb_branch", cdb_branch, 0);
    checkOutput("rst_res", cdb_branch_res, 0);
    checkOutput("rst_addr", cdb_bpb_addr, 0);
    checkOutput("rst_flush", flush, 0);
    checkOutput("rst_flush_pc", flush_pc, 0);

    // Fill the queue with addr 1..4, all predicted taken
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, BPB_ADDR'(i + 1), 1'b1, 32'h200 + 32'(i), 1'b0, '0, 1'b0);
      checkOutput($sformatf("push_tag%0d", i), brq_tag_du, 64'(i));
      tick();
    end
    checkOutput("fill_count", brq_count, 4);
    checkOutput("fill_full", brq_full, 1);

    applyStimulus(1'b1, 3'd7, 1'b0, 32'hdead, 1'b0, '0, 1'b0);
    tick();
    checkOutput("overfill_count", brq_count, 4);
    checkOutput("overfill_tag", brq_tag_du, 0);

    // Resolve tag 2 first: head not resolved, so nothing retires
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 2'd2, 1'b1);
    tick();
    idle();
    tick();
    checkOutput("ooo_no_retire", cdb_branch, 0);
    checkOutput("ooo_count", brq_count, 4);

    // Resolve head in cycle N, training pulse in N+2
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 2'd0, 1'b1);
    tick();
    idle();
    checkOutput("n1_no_pulse", cdb_branch, 0);
    tick();
    checkOutput("n2_branch", cdb_branch, 1);
    checkOutput("n2_res", cdb_branch_res, 1);
    checkOutput("n2_addr", cdb_bpb_addr, 1);
    checkOutput("n2_flush", flush, 0);
    checkOutput("n2_count", brq_count, 3);
    tick();
    checkOutput("n3_pulse_end", cdb_branch, 0);
    checkOutput("n3_tag1_waits", brq_count, 3);

    // Refill to full, then correct retire of head with a same-cycle push
    applyStimulus(1'b1, 3'd6, 1'b1, 32'h240, 1'b0, '0, 1'b0);
    tick();
    checkOutput("refill_full", brq_full, 1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 2'd1, 1'b1);
    tick();
    applyStimulus(1'b1, 3'd5, 1'b1, 32'h250, 1'b0, '0, 1'b0);
    tick();
    idle();
    checkOutput("fullret_count", brq_count, 3);
    checkOutput("fullret_branch", cdb_branch, 1);
    checkOutput("fullret_addr", cdb_bpb_addr, 2);
    checkOutput("fullret_tag", brq_tag_du, 1);
    tick();
    checkOutput("tag2_retire_addr", cdb_bpb_addr, 3);
    checkOutput("tag2_retire_count", brq_count, 2);
    tick();
    checkOutput("idle_no_pulse", cdb_branch, 0);
    checkOutput("idle_addr_hold", cdb_bpb_addr, 3);

    // Correct retire plus push below capacity: count unchanged
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 2'd3, 1'b1);
    tick();
    applyStimulus(1'b1, 3'd7, 1'b1, 32'h270, 1'b0, '0, 1'b0);
    tick();
    idle();
    checkOutput("pushret_count", brq_count, 2);
    checkOutput("pushret_addr", cdb_bpb_addr, 4);
    checkOutput("pushret_tag", brq_tag_du, 2);

    // Mispredicted retire with pushes on the retire and flush cycles
    doReset();
    applyStimulus(1'b1, 3'd5, 1'b0, 32'h100, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 2'd0, 1'b1);
    tick();
    applyStimulus(1'b1, 3'd2, 1'b1, 32'h111, 1'b0, '0, 1'b0);
    tick();
    checkOutput("mis_branch", cdb_branch, 1);
    checkOutput("mis_res", cdb_branch_res, 1);
    checkOutput("mis_addr", cdb_bpb_addr, 5);
    checkOutput("mis_flush", flush, 1);
    checkOutput("mis_flush_pc", flush_pc, 32'h100);
    checkOutput("mis_count", brq_count, 0);
    checkOutput("mis_tag", brq_tag_du, 0);
    applyStimulus(1'b1, 3'd2, 1'b1, 32'h111, 1'b1, 2'd0, 1'b0);
    tick();
    idle();
    checkOutput("flushcyc_count", brq_count, 0);
    checkOutput("flushcyc_tag", brq_tag_du, 0);
    checkOutput("flushcyc_flush_low", flush, 0);
    checkOutput("flushcyc_pc_hold", flush_pc, 32'h100);
    checkOutput("flushcyc_no_pulse", cdb_branch, 0);
    applyStimulus(1'b1, 3'd3, 1'b1, 32'h120, 1'b0, '0, 1'b0);
    tick();
    idle();
    checkOutput("post_flush_count", brq_count, 1);
    checkOutput("post_flush_tag", brq_tag_du, 1);

    // Reset overrides a pending mispredicted retire
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, BPB_ADDR'(i + 1), (i != 0), 32'h300 + 32'(i), 1'b0, '0, 1'b0);
      tick();
    end
    checkOutput("pre_rst_count", brq_count, 3);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 2'd0, 1'b1);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstovr_count", brq_count, 0);
    checkOutput("rstovr_branch", cdb_branch, 0);
    checkOutput("rstovr_flush", flush, 0);
    checkOutput("rstovr_flush_pc", flush_pc, 0);
    checkOutput("rstovr_tag", brq_tag_du, 0);
    tick();
    checkOutput("rstovr_no_pulse", cdb_branch, 0);
    checkOutput("rstovr_no_flush", flush, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
